// File: rtl/stream_logic_pkg.sv
// Shared types and the two-input bit operator for the streaming logic reducer.
package stream_logic_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_NAND = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Base operator on one bit. NAND folds with AND; its inversion is applied
  // only once, at the packet output.
  function automatic logic op_bit(input logic a, input logic b, input mode_t m);
    logic r;
    case (m)
      MODE_OR:  r = a | b;
      MODE_XOR: r = a ^ b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stream_logic_reduce_lane_reduce.sv
// Combinational OPS-to-1 bitwise reduction of WIDTH-bit lanes.
module lane_reduce
  import stream_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPS   = 2
) (
  input  logic [OPS*WIDTH-1:0] in_data,
  input  mode_t                mode,
  output logic [WIDTH-1:0]     result
);

  // Fold lanes 1..OPS-1 into lane 0 with the base operator.
  always_comb begin
    result = in_data[WIDTH-1:0];
    for (int k = 1; k < OPS; k++) begin
      for (int b = 0; b < WIDTH; b++) begin
        result[b] = op_bit(result[b], in_data[k*WIDTH+b], mode);
      end
    end
  end

endmodule

// File: rtl/stream_logic_reduce.sv
// Streaming bitwise reducer: lanes combined per beat, beats folded per packet,
// one registered result per packet over valid/ready.
//
// state  | meaning
// S_IDLE | no partial packet, next beat starts a packet
// S_ACC  | partial packet held in acc_q, mode latched in mode_q
// S_OUT  | result held on out_data/out_beats until out_ready
module stream_logic_reduce
  import stream_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPS   = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPS*WIDTH-1:0] in_data,
  input  logic                 in_last,
  input  logic [MODE_W-1:0]    in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_W-1:0]     out_beats
);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_beats_q, out_beats_d;

  mode_t             beat_mode;
  logic [WIDTH-1:0]  beat_res;
  logic [WIDTH-1:0]  fold_res;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;

  // The first beat uses the incoming mode; later beats use the latched one.
  assign beat_mode = (state_q == S_IDLE) ? mode_t'(in_mode) : mode_q;
  assign in_ready  = (state_q != S_OUT);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

  lane_reduce #(
    .WIDTH (WIDTH),
    .OPS   (OPS)
  ) u_lane_reduce (
    .in_data (in_data),
    .mode    (beat_mode),
    .result  (beat_res)
  );

  // Fold the current beat into the accumulator; saturating beat count.
  always_comb begin
    fold_res = acc_q;
    for (int b = 0; b < WIDTH; b++) begin
      fold_res[b] = op_bit(acc_q[b], beat_res[b], mode_q);
    end
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state, accumulator, counter and output-register updates.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d = mode_t'(in_mode);
          acc_d  = beat_res;
          cnt_d  = CNT_W'(1);
          if (in_last) begin
            out_data_d  = (mode_t'(in_mode) == MODE_NAND) ? ~beat_res : beat_res;
            out_beats_d = CNT_W'(1);
            state_d     = S_OUT;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_d = fold_res;
          cnt_d = cnt_inc;
          if (in_last) begin
            out_data_d  = (mode_q == MODE_NAND) ? ~fold_res : fold_res;
            out_beats_d = cnt_inc;
            state_d     = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registers; reset discards any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

endmodule

// File: tb/tb_stream_logic_reduce.sv
// Directed bench for stream_logic_reduce: base config, saturating counter
// config, and a wide config against a flattened reference model.
module tb_stream_logic_reduce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // dut0: WIDTH=4 OPS=2 CNT_W=8
  logic       in_valid0 = 0, in_last0 = 0, out_ready0 = 0;
  logic [7:0] in_data0 = '0;
  logic [1:0] in_mode0 = '0;
  logic       in_ready0, out_valid0;
  logic [3:0] out_data0;
  logic [7:0] out_beats0;

  // dut1: WIDTH=4 OPS=2 CNT_W=3
  logic       in_valid1 = 0, in_last1 = 0, out_ready1 = 0;
  logic [7:0] in_data1 = '0;
  logic [1:0] in_mode1 = '0;
  logic       in_ready1, out_valid1;
  logic [3:0] out_data1;
  logic [2:0] out_beats1;

  // dut2: WIDTH=16 OPS=8 CNT_W=8
  logic         in_valid2 = 0, in_last2 = 0, out_ready2 = 0;
  logic [127:0] in_data2 = '0;
  logic [1:0]   in_mode2 = '0;
  logic         in_ready2, out_valid2;
  logic [15:0]  out_data2;
  logic [7:0]   out_beats2;

  stream_logic_reduce #(.WIDTH(4), .OPS(2), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_last(in_last0), .in_mode(in_mode0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_beats(out_beats0));

  stream_logic_reduce #(.WIDTH(4), .OPS(2), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_last(in_last1), .in_mode(in_mode1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_beats(out_beats1));

  stream_logic_reduce #(.WIDTH(16), .OPS(8), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_last(in_last2), .in_mode(in_mode2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_beats(out_beats2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic drive0(input logic [7:0] d, input logic last, input logic [1:0] m);
    in_valid0 = 1'b1; in_data0 = d; in_last0 = last; in_mode0 = m;
    @(negedge clk);
    in_valid0 = 1'b0;
  endtask

  task automatic ack0();
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
  endtask

  task automatic drive1(input logic [7:0] d, input logic last, input logic [1:0] m);
    in_valid1 = 1'b1; in_data1 = d; in_last1 = last; in_mode1 = m;
    @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  task automatic drive2(input logic [127:0] d, input logic last, input logic [1:0] m);
    in_valid2 = 1'b1; in_data2 = d; in_last2 = last; in_mode2 = m;
    @(negedge clk);
    in_valid2 = 1'b0;
  endtask

  logic [127:0] rnd;
  logic [15:0]  exp2;
  int           nb;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_beats", out_beats0, 0);
    chk("rst_in_ready", in_ready0, 1);

    // AND single beat: a=1100 b=1010 -> 1000
    drive0({4'b1010, 4'b1100}, 1'b1, 2'd0);
    chk("and_valid", out_valid0, 1);
    chk("and_data", out_data0, 4'b1000);
    chk("and_beats", out_beats0, 1);
    chk("and_in_ready", in_ready0, 0);
    ack0();
    chk("and_ack_valid", out_valid0, 0);
    chk("and_ack_ready", in_ready0, 1);

    // OR three beats, AND offered on beat 2 is ignored -> 1011
    drive0({4'b0000, 4'b0001}, 1'b0, 2'd1);
    chk("or_mid_valid", out_valid0, 0);
    chk("or_mid_ready", in_ready0, 1);
    drive0({4'b0000, 4'b0010}, 1'b0, 2'd0);
    drive0({4'b1000, 4'b0000}, 1'b1, 2'd1);
    chk("or_data", out_data0, 4'b1011);
    chk("or_beats", out_beats0, 3);
    ack0();

    // XOR two beats: (1111^0101)^(0011^0000) = 1001
    drive0({4'b0101, 4'b1111}, 1'b0, 2'd2);
    drive0({4'b0000, 4'b0011}, 1'b1, 2'd2);
    chk("xor_data", out_data0, 4'b1001);
    chk("xor_beats", out_beats0, 2);
    ack0();

    // NAND single beat -> 0111, then stall with beats offered
    drive0({4'b1010, 4'b1100}, 1'b1, 2'd3);
    chk("nand_data", out_data0, 4'b0111);
    chk("nand_beats", out_beats0, 1);
    in_valid0 = 1'b1; in_data0 = 8'h00; in_last0 = 1'b1; in_mode0 = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid0, 1);
      chk("stall_data", out_data0, 4'b0111);
      chk("stall_ready", in_ready0, 0);
    end
    in_valid0 = 1'b0;
    chk("stall_beats", out_beats0, 1);
    ack0();
    chk("stall_ack_valid", out_valid0, 0);
    chk("stall_ack_ready", in_ready0, 1);

    // XOR with gaps between beats: 0110 ^ 0011 = 0101
    drive0({4'b0000, 4'b0110}, 1'b0, 2'd2);
    in_data0 = 8'hFF; in_last0 = 1'b1; in_mode0 = 2'd0;
    repeat (3) @(negedge clk);
    chk("gap_hold_valid", out_valid0, 0);
    drive0({4'b0000, 4'b0011}, 1'b1, 2'd2);
    chk("gap_data", out_data0, 4'b0101);
    chk("gap_beats", out_beats0, 2);
    ack0();

    // reset mid-ACC discards the partial packet
    drive0({4'b1111, 4'b1111}, 1'b0, 2'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid0, 0);
    chk("midrst_ready", in_ready0, 1);
    chk("midrst_data", out_data0, 0);
    chk("midrst_beats", out_beats0, 0);
    drive0({4'b0000, 4'b0100}, 1'b1, 2'd1);
    chk("postrst_data", out_data0, 4'b0100);
    chk("postrst_beats", out_beats0, 1);
    ack0();

    // counter saturation with CNT_W=3: 10 all-ones AND beats
    for (int i = 0; i < 10; i++) drive1(8'hFF, (i == 9), 2'd0);
    chk("sat_valid", out_valid1, 1);
    chk("sat_beats", out_beats1, 7);
    chk("sat_data", out_data1, 4'b1111);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;

    // wide config: random data, flattened reference over all lanes and beats
    for (int p = 0; p < 4; p++) begin
      nb = p + 1;
      exp2 = (p == 0 || p == 3) ? 16'hFFFF : 16'h0000;
      for (int bt = 0; bt < nb; bt++) begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        for (int l = 0; l < 8; l++) begin
          case (p)
            1:       exp2 = exp2 | rnd[l*16 +: 16];
            2:       exp2 = exp2 ^ rnd[l*16 +: 16];
            default: exp2 = exp2 & rnd[l*16 +: 16];
          endcase
        end
        drive2(rnd, (bt == nb - 1), p[1:0]);
      end
      if (p == 3) exp2 = ~exp2;
      chk("wide_valid", out_valid2, 1);
      chk("wide_data", out_data2, exp2);
      chk("wide_beats", out_beats2, nb);
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
